addr_mode_sequencer: RTL
========================

Name: addr_mode_sequencer

Overview:
- Parametrised, self-sequencing effective-address (EA) generator. It succeeds the per-state combinational addressing-mode flag decoders.
- It owns its own state machine and fetches operand and pointer bytes over a request/valid memory handshake, which tolerates variable memory latency.
- It computes the EA with zero-page wrap and index add, inserts a page-cross fixup cycle, and models JMP-indirect page wrap as an option.
- It sits between the instruction decoder (start/mode) and the memory interface. The main control FSM waits on ea_valid before its execute cycles.

Parameters:
- DATA_W, 8: data width. ADDR_W = 2*DATA_W is derived, not overridable. The zero page is the addresses whose high byte is 0.
- JMP_PAGE_BUG, 1: for IND mode, 1 means the pointer high-byte fetch wraps within the page; 0 means it carries into the next page.
- STORE_ALWAYS_FIXUP, 1: for indexed absolute and (ind),Y modes, 1 means stores always take the fixup cycle.
- READ_ALWAYS_FIXUP, 0: 1 means reads always take the fixup cycle, even with no page cross.

Ports:
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- start  in  1  begin a sequence; sampled only in IDLE
- mode  in  4  0 IMM, 1 ZPG, 2 ZPG_X, 3 ZPG_Y, 4 ABS, 5 ABS_X, 6 ABS_Y, 7 IND_X, 8 IND_Y, 9 IND; 10-15 illegal
- is_store  in  1  instruction writes memory
- x_reg  in  DATA_W  X index
- y_reg  in  DATA_W  Y index
- pc  in  ADDR_W  address of the first operand byte
- rd_data  in  DATA_W  memory read data
- rd_valid  in  1  rd_data valid for the current request
- bus_req  out  1  read request
- bus_addr  out  ADDR_W  read address
- pc_inc  out  1  one-cycle pulse per operand byte consumed
- ea  out  ADDR_W  effective address
- ea_valid  out  1  one-cycle pulse; ea is valid in this cycle
- page_cross  out  1  index add carried out of the low byte; valid with ea_valid
- busy  out  1  state is not IDLE
- err  out  1  one-cycle pulse on an illegal mode

Behaviour:
- Reset (asynchronous, nrst=0):
  - State goes to IDLE.
  - All outputs become 0, including ea and bus_addr.
  - All internal registers clear.
  - A reset mid-sequence abandons the sequence. No ea_valid or pc_inc is emitted for it.
- States: IDLE, OP_LO, OP_HI, PTR_LO, PTR_HI, FIXUP, DONE.
- Start:
  - In IDLE, start=1 latches mode, is_store, x_reg, y_reg and pc. Later input changes have no effect on the sequence.
  - start in any other state is ignored.
- Memory handshake:
  - In OP_LO, OP_HI, PTR_LO and PTR_HI, bus_req=1 and bus_addr is held stable until rd_valid=1.
  - rd_valid may arrive in the same cycle bus_req rises, or any later cycle.
  - On rd_valid the byte is captured and the state advances on the next edge.
  - rd_valid while bus_req=0 is ignored.
- Operand fetch: OP_LO reads pc and OP_HI reads pc+1 (modulo 2^ADDR_W). Each accepted operand byte pulses pc_inc in its accept cycle.
- Per-mode transitions and EA:
  - IMM: IDLE to DONE. ea=pc. pc_inc pulses in DONE. No bus access.
  - ZPG: OP_LO to DONE. ea={0,lo}.
  - ZPG_X / ZPG_Y: OP_LO to DONE. ea={0,(lo+idx) mod 2^DATA_W}. The carry is discarded and page_cross=0.
  - ABS: OP_LO, OP_HI, DONE. ea={hi,lo}.
  - ABS_X / ABS_Y: OP_LO, OP_HI, then FIXUP if required, then DONE. ea={hi,lo}+idx over the full ADDR_W. page_cross is the carry out of lo+idx.
  - IND_X: OP_LO, PTR_LO, PTR_HI, DONE.
    - p=(op+x) mod 2^DATA_W.
    - PTR_LO reads {0,p}; PTR_HI reads {0,(p+1) mod 2^DATA_W}.
    - ea={ph,pl}.
  - IND_Y: OP_LO, PTR_LO, PTR_HI, then FIXUP if required, then DONE.
    - PTR_LO reads {0,op}; PTR_HI reads {0,(op+1) mod 2^DATA_W}.
    - ea={ph,pl}+y. page_cross is the carry out of pl+y.
  - IND: OP_LO, OP_HI, PTR_LO, PTR_HI, DONE.
    - PTR_LO reads {hi,lo}.
    - PTR_HI reads {hi,(lo+1) mod 2^DATA_W} if JMP_PAGE_BUG=1, else {hi,lo}+1.
    - ea={ph,pl}.
- FIXUP:
  - Taken when page_cross, or (is_store and STORE_ALWAYS_FIXUP), or (!is_store and READ_ALWAYS_FIXUP).
  - Lasts one cycle with no bus request. It adds exactly 1 cycle to the sequence.
- DONE: ea_valid=1 for exactly one cycle, with ea and page_cross valid. Next state is IDLE, and ea holds its value until the next DONE. A start is accepted again the cycle after DONE.
- Illegal mode: err pulses in the cycle after start. No bus_req or pc_inc is issued, ea_valid stays 0, and the state remains IDLE.
- Latency with rd_valid always 1 (start cycle = 0): ea_valid arrives at cycle
  - IMM 1
  - ZPG/ZPG_X 2
  - ABS 3
  - ABS_X 3, or 4 with fixup
  - IND_X 4
  - IND_Y 4, or 5 with fixup
  - IND 5
- Each memory wait cycle adds one cycle to these figures.

Test Plan:
- ZPG_X wrap: pc=0x0200, mem[0x0200]=0xF0, x=0x20 -> bus_addr 0x0200 requested; ea=0x0010 at cycle 2; page_cross=0; one pc_inc.
- ABS_Y page cross read: operand bytes lo=0xFF, hi=0x12, y=0x01, is_store=0 -> FIXUP taken; ea=0x1300, page_cross=1 at cycle 4. Repeat with y=0x00: ea=0x12FF at cycle 3, page_cross=0.
- IND_Y with memory wait: op=0x80, mem[0x0080]=0x34, mem[0x0081]=0x12, y=0x10, rd_valid delayed 2 cycles per request -> bus_addr held during each wait; ea=0x1244 with no fixup; 3 requests total; 1 pc_inc.
- IND page wrap: pointer=0x30FF, mem[0x30FF]=0x80, mem[0x3000]=0x50, mem[0x3100]=0x60 -> JMP_PAGE_BUG=1 gives ea=0x5080; JMP_PAGE_BUG=0 gives ea=0x6080.
- Store fixup and IND_X: ABS_X, lo=0x10, x=0x01, is_store=1 -> FIXUP taken, page_cross=0, ea=0x..11 at cycle 4. IND_X op=0xFF, x=0x01 -> pointer reads at 0x0000 and 0x0001.
- Reset/illegal/ignored start: nrst low during PTR_LO -> all outputs 0 immediately, no ea_valid, IDLE after release. mode=12 -> err single pulse, no bus_req. start held high during busy -> exactly one sequence.

Source files
------------

// File: rtl/addr_mode_sequencer.sv
// Effective-address generator that fetches operand/pointer bytes over a req/valid
// read port, applying zero-page wrap, index add, page-cross fixup and JMP-indirect wrap.
`timescale 1ns/1ps
module addr_mode_sequencer #(
  parameter int DATA_W             = 8,
  parameter int JMP_PAGE_BUG       = 1,
  parameter int STORE_ALWAYS_FIXUP = 1,
  parameter int READ_ALWAYS_FIXUP  = 0,
  localparam int ADDR_W            = 2 * DATA_W
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic [3:0]        mode,
  input  logic              is_store,
  input  logic [DATA_W-1:0] x_reg,
  input  logic [DATA_W-1:0] y_reg,
  input  logic [ADDR_W-1:0] pc,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_valid,
  output logic              bus_req,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              pc_inc,
  output logic [ADDR_W-1:0] ea,
  output logic              ea_valid,
  output logic              page_cross,
  output logic              busy,
  output logic              err
);

  localparam logic [3:0] M_IMM   = 4'd0;
  localparam logic [3:0] M_ZPG   = 4'd1;
  localparam logic [3:0] M_ZPG_X = 4'd2;
  localparam logic [3:0] M_ZPG_Y = 4'd3;
  localparam logic [3:0] M_ABS   = 4'd4;
  localparam logic [3:0] M_ABS_Y = 4'd6;
  localparam logic [3:0] M_IND_X = 4'd7;
  localparam logic [3:0] M_IND_Y = 4'd8;
  localparam logic [3:0] M_IND   = 4'd9;

  localparam logic [DATA_W-1:0] ZP = '0;

  typedef enum logic [2:0] {IDLE, OP_LO, OP_HI, PTR_LO, PTR_HI, FIXUP, DONE} state_t;

  state_t            state;
  logic [3:0]        mode_q;
  logic              store_q;
  logic [DATA_W-1:0] x_q, y_q, lo_q, pl_q;
  logic [ADDR_W-1:0] pc_q, ea_pend;
  logic              cross_pend, imm_inc;

  logic [DATA_W-1:0] idx, base_lo;
  logic [ADDR_W-1:0] ix_ea, ptr_hi_addr;
  logic              ix_cross, need_fix;

  // Index add shared by ABS_X/ABS_Y (OP_HI) and IND_Y (PTR_HI); rd_data is the high byte
  always_comb begin
    idx         = (mode_q == M_ABS_Y || mode_q == M_IND_Y || mode_q == M_ZPG_Y) ? y_q : x_q;
    base_lo     = (state == OP_HI) ? lo_q : pl_q;
    ix_ea       = {rd_data, base_lo} + ADDR_W'(idx);
    ix_cross    = (ix_ea[ADDR_W-1:DATA_W] != rd_data);
    need_fix    = ix_cross | (store_q & (STORE_ALWAYS_FIXUP != 0))
                | (!store_q & (READ_ALWAYS_FIXUP != 0));
    ptr_hi_addr = (mode_q == M_IND && JMP_PAGE_BUG == 0) ? bus_addr + ADDR_W'(1)
                : {bus_addr[ADDR_W-1:DATA_W], bus_addr[DATA_W-1:0] + DATA_W'(1)};
  end

  assign busy   = (state != IDLE);
  assign pc_inc = imm_inc | (bus_req & rd_valid & (state == OP_LO || state == OP_HI));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      mode_q     <= '0;
      store_q    <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      lo_q       <= '0;
      pl_q       <= '0;
      pc_q       <= '0;
      ea_pend    <= '0;
      cross_pend <= 1'b0;
      imm_inc    <= 1'b0;
      bus_req    <= 1'b0;
      bus_addr   <= '0;
      ea         <= '0;
      ea_valid   <= 1'b0;
      page_cross <= 1'b0;
      err        <= 1'b0;
    end else begin
      ea_valid <= 1'b0;
      err      <= 1'b0;
      imm_inc  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          mode_q  <= mode;
          store_q <= is_store;
          x_q     <= x_reg;
          y_q     <= y_reg;
          pc_q    <= pc;
          if (mode == M_IMM) begin
            ea         <= pc;
            page_cross <= 1'b0;
            ea_valid   <= 1'b1;
            imm_inc    <= 1'b1;
            state      <= DONE;
          end else if (mode > M_IND) begin
            err <= 1'b1;
          end else begin
            bus_req  <= 1'b1;
            bus_addr <= pc;
            state    <= OP_LO;
          end
        end
        OP_LO: if (rd_valid) begin
          lo_q <= rd_data;
          case (mode_q)
            M_ZPG, M_ZPG_X, M_ZPG_Y: begin
              ea         <= {ZP, (mode_q == M_ZPG) ? rd_data : rd_data + idx};
              page_cross <= 1'b0;
              ea_valid   <= 1'b1;
              bus_req    <= 1'b0;
              state      <= DONE;
            end
            M_IND_X: begin
              bus_addr <= {ZP, rd_data + x_q};
              state    <= PTR_LO;
            end
            M_IND_Y: begin
              bus_addr <= {ZP, rd_data};
              state    <= PTR_LO;
            end
            default: begin
              bus_addr <= pc_q + ADDR_W'(1);
              state    <= OP_HI;
            end
          endcase
        end
        OP_HI: if (rd_valid) begin
          if (mode_q == M_ABS) begin
            ea         <= {rd_data, lo_q};
            page_cross <= 1'b0;
            ea_valid   <= 1'b1;
            bus_req    <= 1'b0;
            state      <= DONE;
          end else if (mode_q == M_IND) begin
            bus_addr <= {rd_data, lo_q};
            state    <= PTR_LO;
          end else begin
            ea_pend    <= ix_ea;
            cross_pend <= ix_cross;
            bus_req    <= 1'b0;
            if (need_fix) begin
              state <= FIXUP;
            end else begin
              ea         <= ix_ea;
              page_cross <= ix_cross;
              ea_valid   <= 1'b1;
              state      <= DONE;
            end
          end
        end
        PTR_LO: if (rd_valid) begin
          pl_q     <= rd_data;
          bus_addr <= ptr_hi_addr;
          state    <= PTR_HI;
        end
        PTR_HI: if (rd_valid) begin
          bus_req <= 1'b0;
          if (mode_q == M_IND_Y) begin
            ea_pend    <= ix_ea;
            cross_pend <= ix_cross;
            if (need_fix) begin
              state <= FIXUP;
            end else begin
              ea         <= ix_ea;
              page_cross <= ix_cross;
              ea_valid   <= 1'b1;
              state      <= DONE;
            end
          end else begin
            ea         <= {rd_data, pl_q};
            page_cross <= 1'b0;
            ea_valid   <= 1'b1;
            state      <= DONE;
          end
        end
        FIXUP: begin
          ea         <= ea_pend;
          page_cross <= cross_pend;
          ea_valid   <= 1'b1;
          state      <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
